// File: rtl/key_debouncer_pkg.sv
// Shared types and helpers for the multi-channel key debouncer.
package key_debouncer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RPT  = 2'd2
  } rpt_state_t;

  // Width of the hold/repeat counter: wide enough for the larger of the two
  // intervals, with one spare bit of headroom.
  function automatic int hcnt_width(input int hold_delay, input int repeat_period);
    int m;
    m = (hold_delay > repeat_period) ? hold_delay : repeat_period;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// One debouncer channel: synchroniser, saturating integrator, edge pulses
// and the auto-repeat state machine.
module key_debounce_channel
  import key_debouncer_pkg::*;
#(
  parameter int WIDTH         = 20,
  parameter bit INVERT_BIT    = 1'b0,
  parameter bit REPEAT_EN     = 1'b0,
  parameter int HOLD_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic level,
  output logic press_p,
  output logic release_p,
  output logic repeat_p
);

  localparam int               HW        = hcnt_width(HOLD_DELAY, REPEAT_PERIOD);
  localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_DELAY - 1);
  localparam logic [HW-1:0]    RPT_LAST  = HW'(REPEAT_PERIOD - 1);
  localparam logic [WIDTH-1:0] CNT_MAX   = '1;

  logic             sync_p0;
  logic             sync_p1;
  logic [WIDTH-1:0] cnt;
  logic             at_top;
  logic             at_bottom;
  logic             set_edge;
  logic             clr_edge;
  rpt_state_t       state;
  rpt_state_t       state_nx;
  logic [HW-1:0]    hcnt;
  logic [HW-1:0]    hcnt_nx;
  logic             rpt_nx;

  // Saturating up/down step: the integrator never wraps in either direction.
  function automatic logic [WIDTH-1:0] sat_step(input logic [WIDTH-1:0] c, input logic up);
    if (up) return (c == CNT_MAX) ? c : c + 1'b1;
    else    return (c == '0)      ? c : c - 1'b1;
  endfunction

  // Stage p0/p1: two-flop synchroniser; polarity is folded in ahead of the
  // first flop so an active-low key also reads as released out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= in ^ INVERT_BIT;
      sync_p1 <= sync_p0;
    end
  end

  assign at_top    = (cnt == CNT_MAX);
  assign at_bottom = (cnt == '0);
  assign set_edge  = sync_p1 & at_top & ~level;
  assign clr_edge  = ~sync_p1 & at_bottom & level;

  // Integrator with hysteresis: level only moves at the saturation points,
  // and the press/release pulses are registered on those same edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      level     <= 1'b0;
      press_p   <= 1'b0;
      release_p <= 1'b0;
    end else begin
      cnt       <= sat_step(cnt, sync_p1);
      press_p   <= set_edge;
      release_p <= clr_edge;
      if (sync_p1 && at_top)
        level <= 1'b1;
      else if (!sync_p1 && at_bottom)
        level <= 1'b0;
    end
  end

  // Repeat FSM state, hold counter and registered repeat pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hcnt     <= '0;
      repeat_p <= 1'b0;
    end else begin
      state    <= state_nx;
      hcnt     <= hcnt_nx;
      repeat_p <= rpt_nx;
    end
  end

  // Next-state logic: a clearing edge always wins over a due repeat pulse,
  // so repeat_p can never coincide with release_p.
  always_comb begin
    state_nx = state;
    hcnt_nx  = hcnt;
    rpt_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        if (REPEAT_EN && set_edge) begin
          state_nx = HOLD;
          hcnt_nx  = '0;
        end
      end
      HOLD: begin
        if (clr_edge) begin
          state_nx = IDLE;
          hcnt_nx  = '0;
        end else if (hcnt == HOLD_LAST) begin
          rpt_nx   = 1'b1;
          state_nx = RPT;
          hcnt_nx  = '0;
        end else begin
          hcnt_nx  = hcnt + 1'b1;
        end
      end
      RPT: begin
        if (clr_edge) begin
          state_nx = IDLE;
          hcnt_nx  = '0;
        end else if (hcnt == RPT_LAST) begin
          rpt_nx   = 1'b1;
          hcnt_nx  = '0;
        end else begin
          hcnt_nx  = hcnt + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        hcnt_nx  = '0;
      end
    endcase
  end

endmodule

// File: rtl/key_debouncer.sv
// Multi-channel key debouncer: one independent channel per input pin.
module key_debouncer
  import key_debouncer_pkg::*;
#(
  parameter int                  CHANNELS      = 4,
  parameter int                  WIDTH         = 20,
  parameter logic [CHANNELS-1:0] INVERT        = '0,
  parameter logic [CHANNELS-1:0] REPEAT_MASK   = '0,
  parameter int                  HOLD_DELAY    = 25_000_000,
  parameter int                  REPEAT_PERIOD = 5_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press_p,
  output logic [CHANNELS-1:0] release_p,
  output logic [CHANNELS-1:0] repeat_p
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    key_debounce_channel #(
      .WIDTH        (WIDTH),
      .INVERT_BIT   (INVERT[g]),
      .REPEAT_EN    (REPEAT_MASK[g]),
      .HOLD_DELAY   (HOLD_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .in       (in[g]),
      .level    (level[g]),
      .press_p  (press_p[g]),
      .release_p(release_p[g]),
      .repeat_p (repeat_p[g])
    );
  end

endmodule

// File: tb/tb_key_debouncer.sv
// Testbench for key_debouncer: vector table, directed corner sequences and
// random stimulus, all compared against a behavioural model.
module tb_key_debouncer;

  localparam int         W     = 3;
  localparam int         HOLD  = 20;
  localparam int         PER   = 5;
  localparam logic [3:0] INV   = 4'b1000;
  localparam logic [3:0] RMASK = 4'b0011;
  localparam int         MAXC  = (1 << W) - 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  in_r;
  logic [3:0]  level, press_p, release_p, repeat_p;
  logic [15:0] outs;

  int errors = 0;
  int checks = 0;

  // behavioural model state
  int         m_cnt [4];
  bit         m_lvl [4];
  bit         m_s1  [4];
  bit         m_s2  [4];
  int         m_pcyc[4];
  int         cyc = 0;
  logic [3:0] e_lvl, e_prs, e_rel, e_rpt;
  logic [3:0] inv_v, rmask_v;

  typedef struct {
    logic [3:0] in;
    int         ticks;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rel;
    logic [3:0] rpt;
  } vec_t;
  vec_t vecs[9];

  key_debouncer #(
    .CHANNELS     (4),
    .WIDTH        (W),
    .INVERT       (INV),
    .REPEAT_MASK  (RMASK),
    .HOLD_DELAY   (HOLD),
    .REPEAT_PERIOD(PER)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (in_r),
    .level    (level),
    .press_p  (press_p),
    .release_p(release_p),
    .repeat_p (repeat_p)
  );

  assign outs = {level, press_p, release_p, repeat_p};

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_cnt[i]  = 0;
      m_lvl[i]  = 1'b0;
      m_s1[i]   = 1'b0;
      m_s2[i]   = 1'b0;
      m_pcyc[i] = -1;
    end
    e_lvl = '0; e_prs = '0; e_rel = '0; e_rpt = '0;
  endtask

  // One clock edge of the reference: level follows the integrator's
  // saturation rules; repeats are due at press + HOLD + n*PER while held.
  task automatic model_step();
    logic [3:0] np, nr, nt;
    np = '0; nr = '0; nt = '0;
    cyc++;
    for (int i = 0; i < 4; i++) begin
      bit raw;
      int d;
      raw = m_s2[i];
      if (raw) begin
        if (m_cnt[i] == MAXC) begin
          if (!m_lvl[i]) begin
            np[i] = 1'b1;
            m_pcyc[i] = cyc;
          end
          m_lvl[i] = 1'b1;
        end else begin
          m_cnt[i] = m_cnt[i] + 1;
        end
      end else begin
        if (m_cnt[i] != 0) begin
          m_cnt[i] = m_cnt[i] - 1;
        end else begin
          if (m_lvl[i]) begin
            nr[i] = 1'b1;
            m_pcyc[i] = -1;
          end
          m_lvl[i] = 1'b0;
        end
      end
      if (rmask_v[i] && m_lvl[i] && m_pcyc[i] >= 0) begin
        d = cyc - m_pcyc[i];
        if (d >= HOLD && ((d - HOLD) % PER) == 0) nt[i] = 1'b1;
      end
      m_s2[i] = m_s1[i];
      m_s1[i] = in_r[i] ^ inv_v[i];
      e_lvl[i] = m_lvl[i];
    end
    e_prs = np; e_rel = nr; e_rpt = nt;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    check("model", outs, {e_lvl, e_prs, e_rel, e_rpt});
  endtask

  // Press channel ch, hold for span cycles past the press, optionally
  // releasing so that level clears exactly at press + rel_at.
  task automatic run_hold(input int ch, input int rel_at, input int span, input string name);
    logic [3:0] m;
    bit         er;
    m = 4'b0001 << ch;
    in_r[ch] = 1'b1;
    repeat (10) tick();
    check({name, "_press"}, {12'b0, press_p & m}, {12'b0, m});
    for (int k = 1; k <= span; k++) begin
      if (rel_at != 0 && (k - 1) == rel_at - 10) in_r[ch] = 1'b0;
      tick();
      er = rmask_v[ch] && k >= HOLD && ((k - HOLD) % PER) == 0 && (rel_at == 0 || k < rel_at);
      check({name, "_rpt"}, {15'b0, repeat_p[ch]}, {15'b0, er});
      check({name, "_rel"}, {15'b0, release_p[ch]}, {15'b0, (rel_at != 0 && k == rel_at)});
    end
    if (rel_at == 0) begin
      in_r[ch] = 1'b0;
      repeat (12) tick();
    end else begin
      repeat (2) tick();
    end
  endtask

  initial begin
    int hits;
    inv_v   = INV;
    rmask_v = RMASK;
    model_reset();

    vecs[0] = '{4'b0000, 9, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vecs[1] = '{4'b0000, 1, 4'b1000, 4'b1000, 4'b0000, 4'b0000};
    vecs[2] = '{4'b0000, 1, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    vecs[3] = '{4'b0001, 9, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    vecs[4] = '{4'b0001, 1, 4'b1001, 4'b0001, 4'b0000, 4'b0000};
    vecs[5] = '{4'b0001, 1, 4'b1001, 4'b0000, 4'b0000, 4'b0000};
    vecs[6] = '{4'b0000, 9, 4'b1001, 4'b0000, 4'b0000, 4'b0000};
    vecs[7] = '{4'b0000, 1, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
    vecs[8] = '{4'b0000, 1, 4'b1000, 4'b0000, 4'b0000, 4'b0000};

    // reset asserted mid-clock must clear outputs without an edge
    rst_n = 1'b1;
    in_r  = 4'b0111;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("reset_async", outs, 16'h0000);
    repeat (2) tick();
    in_r  = 4'b0000;
    rst_n = 1'b1;

    // reset release, inverted channel settling, clean press and release
    for (int k = 0; k < 9; k++) begin
      in_r = vecs[k].in;
      repeat (vecs[k].ticks) tick();
      check($sformatf("vec%0d", k), outs, {vecs[k].lvl, vecs[k].prs, vecs[k].rel, vecs[k].rpt});
    end

    // fast bounce on channel 2 never reaches saturation
    hits = 0;
    for (int k = 0; k < 100; k++) begin
      in_r[2] = ~in_r[2];
      tick();
      if (level[2] | press_p[2] | release_p[2] | repeat_p[2]) hits++;
    end
    check("bounce_fast", 16'(hits), 16'h0000);
    in_r[2] = 1'b0;
    repeat (3) tick();

    // saturate channel 2, then a slow bounce must never clear it
    in_r[2] = 1'b1;
    repeat (12) tick();
    check("ch2_sat", {15'b0, level[2]}, 16'h0001);
    hits = 0;
    for (int k = 0; k < 60; k++) begin
      if (k % 3 == 0) in_r[2] = ~in_r[2];
      tick();
      if (!level[2] || release_p[2]) hits++;
    end
    check("bounce_slow", 16'(hits), 16'h0000);
    in_r[2] = 1'b0;
    repeat (12) tick();
    check("ch2_clear", {15'b0, level[2]}, 16'h0000);

    // auto-repeat on an enabled channel, none on a disabled one
    run_hold(1, 0, 31, "rpt1");
    run_hold(2, 0, 40, "norpt2");

    // release during hold and exactly at the first repeat boundary
    run_hold(0, 12, 14, "rel12");
    run_hold(0, 0, 21, "restart_a");
    run_hold(0, 20, 22, "rel20");
    run_hold(0, 0, 21, "restart_b");

    // simultaneous presses, then reset while repeating
    in_r[1:0] = 2'b11;
    repeat (10) tick();
    check("simul_press", {12'b0, press_p}, 16'h0003);
    repeat (25) tick();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_mid_hold", outs, 16'h0000);
    repeat (2) tick();
    rst_n = 1'b1;
    hits = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (release_p != 4'b0000) hits++;
    end
    check("no_release_after_rst", 16'(hits), 16'h0000);
    in_r = 4'b0000;
    repeat (12) tick();

    // random stimulus against the model
    for (int r = 0; r < 150; r++) begin
      in_r = 4'($urandom);
      repeat ($urandom_range(1, 14)) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
